tone_generator: RTL and testbench
=================================

# tone_generator

Square-wave tone generator that sits directly downstream of the note selector. It consumes the selector's 32-bit half-period count (`div_value`) and a key-press level. It drives a 1-bit audio square wave to the speaker/PWM pin. It gives glitch-free pitch changes, a programmable release tail after key-up, and a click-free stop that always ends on a complete low phase.

## Interface
- `CNT_W`, 32: width of `div_value` and the half-period counter.
- `MIN_DIV`, 2: smallest legal half-period; `div_value < MIN_DIV` is clamped to `MIN_DIV`.
- `RELEASE_CYCLES`, 5_000_000: clocks the tone continues after key release (50 ms at 100 MHz); 0 = no tail.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_on` in 1: level, high while a note key is held; synchronous to `clk`.
- `div_value` in CNT_W: half-period length in clocks, from the note selector.
- `audio_out` out 1: square-wave output, registered.
- `playing` out 1: high whenever state is not IDLE, registered.
- `period_tick` out 1: one-cycle pulse in the first cycle of each new `audio_out` level.

## Operation
- States: IDLE, PLAY, RELEASE, STOP.
- Internal registers: `div_lat` (latched half-period), `cnt` (CNT_W), `rel_cnt`.
- Toggle point: `cnt == div_lat-1` in any non-IDLE state. At the toggle point, `cnt` returns to 0, `div_lat` reloads from the clamped `div_value`, and `period_tick` asserts next cycle. Otherwise `cnt` increments by 1.
- Pitch changes take effect only at a toggle point. Every high or low phase lasts exactly the `div_lat` value latched at its start.
- IDLE → PLAY when `key_on`=1:
  - `div_lat` is loaded from the clamped `div_value` and `cnt` is set to 0.
  - `audio_out` is set to 1 and `period_tick` to 1 on the same edge.
- PLAY:
  - Toggle `audio_out` at each toggle point.
  - `key_on`=0 → RELEASE with `rel_cnt`=0. If `RELEASE_CYCLES`=0, go to STOP instead.
- RELEASE:
  - Waveform continues unchanged and `rel_cnt` increments.
  - `key_on`=1 → PLAY, `rel_cnt` cleared, phase and `cnt` undisturbed.
  - `rel_cnt == RELEASE_CYCLES-1` → STOP.
  - If `key_on`=1 and the release expiry fall in the same cycle, `key_on` wins and the next state is PLAY.
- STOP:
  - `key_on`=1 → PLAY (restrike), phase undisturbed.
  - At the next toggle point, if `audio_out`=1: drive `audio_out` to 0, pulse `period_tick`, go to IDLE. If `audio_out`=0: go to IDLE with no toggle and no tick.
  - The final low phase is therefore always complete.
  - If `key_on`=1 arrives in the same cycle as the toggle point, the result is PLAY with a normal toggle.
- IDLE: `cnt` is held at 0. `audio_out`, `period_tick` and `playing` are 0. `div_value` is ignored.
- Arithmetic:
  - Clamp is `div_eff = (div_value < MIN_DIV) ? MIN_DIV : div_value`.
  - `cnt` never exceeds `div_lat-1`, so there is no wrap.
  - An all-ones `div_value` is legal and produces 2^CNT_W-1-cycle phases.

## Timing
- Reset (async assert, sync release):
  - State IDLE; `cnt`, `rel_cnt` = 0; `div_lat` = `MIN_DIV`.
  - `audio_out`, `playing`, `period_tick` = 0.
  - Assertion mid-tone forces `audio_out` to 0 immediately.
- Key-on latency: `key_on` sampled high at edge N gives `audio_out`=1, `playing`=1 and `period_tick`=1 after edge N.
- Output period is 2·`div_lat` clocks. With 100 MHz and `div_value`=191571 (C4), the output is ≈261 Hz.
- Key-up to silence: `RELEASE_CYCLES` + 1 clocks (RELEASE entry plus STOP entry), plus up to 2·`div_lat` clocks to finish the waveform.
- `playing` falls on the same edge `audio_out` reaches its final 0 or STOP exits.
- `period_tick` is never high for two consecutive cycles, since `div_lat` ≥ 2.

## Test plan
- Basic tone: `div_value`=4, `key_on` held → `audio_out` is 1 for 4 clocks then 0 for 4, repeating; `period_tick` pulses every 4 clocks; `playing`=1.
- Glitch-free retune: `div_value` changes 4→6 mid high-phase → the current phase still lasts 4 clocks; all following phases last 6.
- Clamp: `div_value`=0 and 1 → phases of 2 clocks each.
- Release/stop (RELEASE_CYCLES=10, div=4):
  - `key_on` dropped → tone continues 10 clocks, then ends at the next toggle point.
  - If output was high at that point, it goes low and `playing` drops on that edge.
  - If output was low, `playing` drops at the end of that low phase and no extra tick occurs.
- Restrike: `key_on` reasserted during RELEASE and during STOP → returns to PLAY with no phase discontinuity (tick spacing stays 4). Simultaneous `key_on` with the expiry or toggle point → PLAY.
- Reset mid-tone: `rst_n` low while `audio_out`=1 → `audio_out`, `playing`, `period_tick` are 0 asynchronously. After release with `key_on`=1, the tone restarts with `cnt`=0 and `audio_out`=1 after one edge.

Source files
------------

// File: rtl/tone_generator_if.sv
// Note-selector / speaker side of the tone generator: half-period and key level in,
// square wave with its status and phase-tick out.
interface tone_generator_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             key_on;
  logic [CNT_W-1:0] div_value;
  logic             audio_out;
  logic             playing;
  logic             period_tick;

  modport master (
    output key_on,
    output div_value,
    input  audio_out,
    input  playing,
    input  period_tick
  );

  modport slave (
    input  key_on,
    input  div_value,
    output audio_out,
    output playing,
    output period_tick
  );
endinterface

// File: rtl/tone_generator.sv
// Square-wave tone generator: glitch-free pitch changes at phase boundaries,
// release tail after key-up and a stop that always finishes on a complete phase.
module tone_generator #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned MIN_DIV        = 2,
  parameter int unsigned RELEASE_CYCLES = 5_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  tone_generator_if.slave  tone
);

  localparam logic [CNT_W-1:0] MIN_LIM  = CNT_W'(MIN_DIV);
  localparam int unsigned      REL_LAST = (RELEASE_CYCLES == 0) ? 0 : RELEASE_CYCLES - 1;
  localparam int unsigned      REL_W    = (REL_LAST > 0) ? $clog2(REL_LAST + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RELEASE,
    STOP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] div_lat, div_lat_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [REL_W-1:0] rel_cnt, rel_cnt_nxt;
  logic             audio_q, audio_nxt;
  logic             tick_q, tick_nxt;
  logic             playing_q, playing_nxt;
  logic [CNT_W-1:0] div_eff;
  logic             at_toggle;

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < MIN_LIM) ? MIN_LIM : d;
  endfunction

  assign div_eff   = clamp_div(tone.div_value);
  assign at_toggle = (state != IDLE) && (cnt == (div_lat - CNT_W'(1)));

  always_comb begin
    state_nxt   = state;
    div_lat_nxt = div_lat;
    cnt_nxt     = cnt;
    rel_cnt_nxt = rel_cnt;
    audio_nxt   = audio_q;
    tick_nxt    = 1'b0;

    // The waveform runs identically in every active state; states only decide when it ends.
    if (state != IDLE) begin
      if (at_toggle) begin
        cnt_nxt     = '0;
        div_lat_nxt = div_eff;
        audio_nxt   = ~audio_q;
        tick_nxt    = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end

    unique case (state)
      IDLE: begin
        cnt_nxt     = '0;
        rel_cnt_nxt = '0;
        audio_nxt   = 1'b0;
        if (tone.key_on) begin
          state_nxt   = PLAY;
          div_lat_nxt = div_eff;
          audio_nxt   = 1'b1;
          tick_nxt    = 1'b1;
        end
      end

      PLAY: begin
        if (!tone.key_on) begin
          rel_cnt_nxt = '0;
          state_nxt   = (RELEASE_CYCLES == 0) ? STOP : RELEASE;
        end
      end

      RELEASE: begin
        if (tone.key_on) begin
          state_nxt   = PLAY;
          rel_cnt_nxt = '0;
        end else if (rel_cnt == REL_W'(REL_LAST)) begin
          state_nxt = STOP;
        end else begin
          rel_cnt_nxt = rel_cnt + REL_W'(1);
        end
      end

      STOP: begin
        if (tone.key_on) begin
          state_nxt = PLAY;
        end else if (at_toggle) begin
          // A low phase that just completed ends silently; a high phase gets its falling edge.
          state_nxt = IDLE;
          cnt_nxt   = '0;
          audio_nxt = 1'b0;
          tick_nxt  = audio_q;
        end
      end

      default: state_nxt = IDLE;
    endcase

    playing_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_lat   <= MIN_LIM;
      cnt       <= '0;
      rel_cnt   <= '0;
      audio_q   <= 1'b0;
      tick_q    <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_lat   <= div_lat_nxt;
      cnt       <= cnt_nxt;
      rel_cnt   <= rel_cnt_nxt;
      audio_q   <= audio_nxt;
      tick_q    <= tick_nxt;
      playing_q <= playing_nxt;
    end
  end

  assign tone.audio_out   = audio_q;
  assign tone.period_tick = tick_q;
  assign tone.playing     = playing_q;

  a_cnt_bounded : assert property (@(posedge clk) disable iff (!rst_n)
    (state != IDLE) |-> (cnt < div_lat));
  a_div_min : assert property (@(posedge clk) disable iff (!rst_n)
    div_lat >= MIN_LIM);

endmodule

// File: tb/tb_tone_generator.sv
// Scoreboard bench for tone_generator: stimulus queues hand-computed tick/stop events,
// a monitor checks each period_tick and each fall of playing against them.
module tb_tone_generator;
  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tone_generator_if #(.CNT_W(CNT_W)) tif ();

  tone_generator #(
    .CNT_W         (CNT_W),
    .MIN_DIV       (2),
    .RELEASE_CYCLES(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tone (tif.slave)
  );

  typedef struct {
    bit is_end;
    bit lvl;
    int gap;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_tick(input bit lvl, input int gap);
    ev_t e;
    e.is_end = 1'b0;
    e.lvl    = lvl;
    e.gap    = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_end(input int gap);
    ev_t e;
    e.is_end = 1'b1;
    e.lvl    = 1'b0;
    e.gap    = gap;
    exp_q.push_back(e);
  endtask

  // n ticks starting high from idle (gap 0), then alternating levels every 'gap' clocks
  task automatic push_alt(input int n, input int gap);
    for (int i = 0; i < n; i++) push_tick((i % 2) == 0, (i == 0) ? 0 : gap);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((tif.playing || exp_q.size() != 0) && n < 300);
    chk({name, "_done"}, longint'(tif.playing || exp_q.size() != 0), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor
  initial begin
    int  cyc;
    int  last_tick;
    int  gap;
    bit  prev_play;
    bit  level;
    ev_t e;
    cyc = 0; last_tick = 0; prev_play = 1'b0; level = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_play = 1'b0;
      end else begin
        if (tif.period_tick) begin
          gap = prev_play ? (cyc - last_tick) : 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_tick", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("tick_kind", e.is_end, 0);
            chk("tick_level", tif.audio_out, e.lvl);
            chk("tick_gap", gap, e.gap);
            level = e.lvl;
          end
          last_tick = cyc;
        end
        if (prev_play && !tif.playing) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_stop", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("stop_kind", e.is_end, 1);
            chk("stop_gap", cyc - last_tick, e.gap);
            chk("stop_audio", tif.audio_out, 0);
          end
        end
        if (tif.playing && !tif.period_tick) chk("level_hold", tif.audio_out, level);
        prev_play = tif.playing;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    tif.key_on    = 1'b0;
    tif.div_value = 32'd4;
    repeat (3) @(negedge clk);
    chk("rst_audio", tif.audio_out, 0);
    chk("rst_playing", tif.playing, 0);
    chk("rst_tick", tif.period_tick, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic tone, release ending on a high phase
    push_alt(6, 4); push_end(0);
    tif.key_on = 1'b1; repeat (9) @(negedge clk); tif.key_on = 1'b0;
    wait_idle("basic_hi");

    // release ending on a low phase: no extra tick
    push_alt(6, 4); push_end(4);
    tif.key_on = 1'b1; repeat (13) @(negedge clk); tif.key_on = 1'b0;
    wait_idle("basic_lo");

    // retune 4 -> 6 during the first high phase
    push_tick(1, 0); push_tick(0, 4); push_tick(1, 6);
    push_tick(0, 6); push_tick(1, 6); push_tick(0, 6); push_end(0);
    tif.key_on = 1'b1; repeat (2) @(negedge clk);
    tif.div_value = 32'd6; repeat (10) @(negedge clk); tif.key_on = 1'b0;
    wait_idle("retune");

    // clamp of 0 and 1 to 2-clock phases
    push_alt(8, 2); push_end(2);
    tif.div_value = 32'd0; tif.key_on = 1'b1; repeat (5) @(negedge clk); tif.key_on = 1'b0;
    wait_idle("clamp0");
    push_alt(10, 2); push_end(0);
    tif.div_value = 32'd1; tif.key_on = 1'b1; repeat (6) @(negedge clk); tif.key_on = 1'b0;
    wait_idle("clamp1");
    tif.div_value = 32'd4;

    // restrike during RELEASE
    push_alt(8, 4); push_end(0);
    tif.key_on = 1'b1; repeat (5) @(negedge clk); tif.key_on = 1'b0;
    repeat (3) @(negedge clk); tif.key_on = 1'b1;
    repeat (9) @(negedge clk); tif.key_on = 1'b0;
    wait_idle("restrike_rel");

    // restrike during STOP, away from a toggle point
    push_alt(12, 4); push_end(0);
    tif.key_on = 1'b1; repeat (6) @(negedge clk); tif.key_on = 1'b0;
    repeat (12) @(negedge clk); tif.key_on = 1'b1;
    repeat (12) @(negedge clk); tif.key_on = 1'b0;
    wait_idle("restrike_stop");

    // restrike on the STOP toggle point
    push_alt(10, 4); push_end(0);
    tif.key_on = 1'b1; repeat (5) @(negedge clk); tif.key_on = 1'b0;
    repeat (11) @(negedge clk); tif.key_on = 1'b1;
    repeat (9) @(negedge clk); tif.key_on = 1'b0;
    wait_idle("restrike_toggle");

    // one-cycle key pulse on the release expiry cycle
    push_alt(8, 4); push_end(0);
    tif.key_on = 1'b1; repeat (5) @(negedge clk); tif.key_on = 1'b0;
    repeat (10) @(negedge clk); tif.key_on = 1'b1;
    repeat (1) @(negedge clk); tif.key_on = 1'b0;
    wait_idle("restrike_expiry");

    // asynchronous reset in the middle of a high phase, restart with key held
    push_tick(1, 0);
    tif.key_on = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_audio", tif.audio_out, 0);
    chk("async_rst_playing", tif.playing, 0);
    chk("async_rst_tick", tif.period_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_alt(6, 4); push_end(0);
    @(posedge clk); #1;
    chk("restart_audio", tif.audio_out, 1);
    chk("restart_tick", tif.period_tick, 1);
    chk("restart_playing", tif.playing, 1);
    repeat (9) @(negedge clk); tif.key_on = 1'b0;
    wait_idle("reset_restart");

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
